// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types for the SRAM memory-side controller: FSM states, op encoding, latched request payload.
// Optional TURN state (used only when SRAM_TURNAROUND_EN is defined) is always present in the enum.
package mem_ctrl_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned LANE_W         = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        NEXT,
        TURN
    } mem_ctrl_state_t;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t                   op;
        logic [DATA_W-1:0]         data;
        logic [BYTES_PER_WORD-1:0] sel;
    } mem_req_t;

    // Lowest set lane of a byte-enable mask; 0 when the mask is empty.
    function automatic logic [LANE_W-1:0] first_lane(input logic [BYTES_PER_WORD-1:0] sel);
        logic [LANE_W-1:0] lane;
        lane = '0;
        for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
            if (sel[i]) lane = LANE_W'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Request/response bus between the request handler (master) and the SRAM controller (slave).
interface sram_mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                      write_to_mem;
    logic                      read_to_mem;
    logic [DATA_W-1:0]         adr_to_mem;
    logic [DATA_W-1:0]         data_to_mem;
    logic [BYTES_PER_WORD-1:0] sel_to_mem;
    logic [DATA_W-1:0]         data_from_mem;
    logic                      mem_busy;

    modport master (
        output write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem,
        input  data_from_mem, mem_busy
    );

    modport slave (
        input  write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem,
        output data_from_mem, mem_busy
    );

endinterface

// File: rtl/sram_mem_ctrl.sv
// Executes one arbitrated 32-bit request as byte phases on a byte-wide asynchronous SRAM.
// Define SRAM_TURNAROUND_EN to insert a one-cycle bus turnaround (TURN) after every byte strobe.
module sram_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_mem_ctrl_if.slave    req,
    output logic [ADDR_W-1:0] sram_adr,
    output logic [7:0]        sram_dq_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int unsigned WORD_W = ADDR_W - LANE_W;
    localparam int unsigned CNT_W  = 4;

    mem_ctrl_state_t   state_q, state_d;
    mem_req_t          cur_q, cur_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] dfm_q, dfm_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [7:0]        dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;

    logic [LANE_W-1:0]         lane_c;
    logic [LANE_W-1:0]         nlane_c;
    logic                      adv_c;
    logic [BYTES_PER_WORD-1:0] adv_sel_c;
    logic [DATA_W-1:0]         rdata_upd_c;

    // Word-alignment bits and bits above the SRAM space are intentionally dropped (aliasing).
    wire unused_adr_bits = ^{req.adr_to_mem[LANE_W-1:0], req.adr_to_mem[DATA_W-1:ADDR_W]};

    assign lane_c = first_lane(cur_q.sel);

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        word_d      = word_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        dfm_d       = dfm_q;
        adr_d       = adr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        adv_c       = 1'b0;
        adv_sel_c   = cur_q.sel;
        rdata_upd_c = rdata_q;
        nlane_c     = '0;

        case (state_q)
            IDLE: begin
                if (req.write_to_mem || req.read_to_mem) begin
                    cur_d.op   = req.write_to_mem ? MEM_OP_WRITE : MEM_OP_READ;
                    cur_d.data = req.data_to_mem;
                    cur_d.sel  = req.sel_to_mem;
                    word_d     = req.adr_to_mem[ADDR_W-1:LANE_W];
                    rdata_d    = '0;
                    busy_d     = 1'b1;
                    if (req.sel_to_mem == '0) begin
                        state_d = NEXT;
                    end else begin
                        adv_c     = 1'b1;
                        adv_sel_c = req.sel_to_mem;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                if (cur_q.op == MEM_OP_WRITE) we_n_d = 1'b0;
                else                          oe_n_d = 1'b0;
            end
            STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (cur_q.op == MEM_OP_READ) rdata_upd_c[{lane_c, 3'b000} +: 8] = sram_dq_i;
                    rdata_d   = rdata_upd_c;
                    adv_sel_c = cur_q.sel & ~(BYTES_PER_WORD'(1) << lane_c);
                    cur_d.sel = adv_sel_c;
                    we_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
`ifdef SRAM_TURNAROUND_EN
                    state_d   = TURN;
                    ce_n_d    = 1'b1;
                    dq_oe_d   = 1'b0;
`else
                    adv_c     = 1'b1;
`endif
                end
            end
            // Only reached for an empty lane mask: one busy cycle, no SRAM access.
            NEXT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            TURN: adv_c = 1'b1;
            default: state_d = IDLE;
        endcase

        // Advance to the next selected lane without an idle cycle, or complete the access.
        if (adv_c) begin
            if (adv_sel_c != '0) begin
                nlane_c = first_lane(adv_sel_c);
                state_d = SETUP;
                adr_d   = {word_d, nlane_c};
                ce_n_d  = 1'b0;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                if (cur_d.op == MEM_OP_WRITE) begin
                    dq_o_d  = cur_d.data[{nlane_c, 3'b000} +: 8];
                    dq_oe_d = 1'b1;
                end else begin
                    dq_oe_d = 1'b0;
                end
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                if (cur_d.op == MEM_OP_READ) dfm_d = rdata_upd_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            dfm_q   <= '0;
            adr_q   <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            dfm_q   <= dfm_d;
            adr_q   <= adr_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign req.mem_busy      = busy_q;
    assign req.data_from_mem = dfm_q;
    assign sram_adr          = adr_q;
    assign sram_dq_o         = dq_o_q;
    assign sram_dq_oe        = dq_oe_q;
    assign sram_ce_n         = ce_n_q;
    assign sram_oe_n         = oe_n_q;
    assign sram_we_n         = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl (WAIT_CYCLES=2, turnaround off) with a byte-array SRAM model.
module tb_sram_mem_ctrl;

    localparam int AW    = 18;
    localparam int WAITC = 2;
    localparam int MEMSZ = 1 << AW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] sram_adr;
    logic [7:0]    sram_dq_o;
    logic [7:0]    sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    sram_mem_ctrl_if bus ();

    sram_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .sram_adr   (sram_adr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model
    logic [7:0] sram    [0:MEMSZ-1];
    logic [7:0] ref_mem [0:MEMSZ-1];

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_adr] : 8'hxx;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_adr] <= sram_dq_o;
    end

    // Bus activity log, sampled mid-cycle
    logic [AW+7:0] we_log[$];
    logic [AW-1:0] re_log[$];
    int            ce_cnt;
    int            overlap;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) we_log.push_back({sram_adr, sram_dq_o});
        if (!sram_ce_n && !sram_oe_n) re_log.push_back(sram_adr);
        if (!sram_oe_n && sram_dq_oe) overlap++;
        if (!sram_ce_n) ce_cnt++;
    end

    int          checks;
    int          passes;
    logic [31:0] exp_dfm;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete access plus reference-model prediction of timing, bus traffic and result.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] adr,
                             input logic [31:0] data, input logic [3:0] sel, input string tag);
        int            n;
        int            busy_cnt;
        int            guard;
        int            fl;
        logic [AW-3:0] w;
        logic [AW-1:0] a;
        logic [31:0]   rword;
        logic [AW+7:0] exp_q[$];
        n     = $countones(sel);
        w     = adr[AW-1:2];
        fl    = 0;
        rword = '0;
        for (int i = 3; i >= 0; i--) if (sel[i]) fl = i;
        we_log.delete();
        re_log.delete();
        ce_cnt = 0;

        @(negedge clk);
        bus.write_to_mem = wr;
        bus.read_to_mem  = rd;
        bus.adr_to_mem   = adr;
        bus.data_to_mem  = data;
        bus.sel_to_mem   = sel;
        @(posedge clk);
        #1;
        bus.write_to_mem = 1'b0;
        bus.read_to_mem  = 1'b0;
        @(negedge clk);
        if (sel != 4'b0000) begin
            check({tag, "_setup_ce"}, 64'(sram_ce_n), 64'(0));
            check({tag, "_setup_adr"}, 64'(sram_adr), 64'({w, 2'(fl)}));
            check({tag, "_setup_strb"}, 64'({sram_we_n, sram_oe_n}), 64'(2'b11));
        end
        busy_cnt = 0;
        guard    = 0;
        while (bus.mem_busy === 1'b1 && guard < 200) begin
            busy_cnt++;
            guard++;
            @(negedge clk);
        end

        // Reference model: byte-addressed memory, ascending lane order, WAIT strobe cycles each
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                a = {w, 2'(i)};
                if (wr) begin
                    ref_mem[a] = data[8*i +: 8];
                    for (int k = 0; k < WAITC; k++) exp_q.push_back({a, data[8*i +: 8]});
                end else begin
                    rword[8*i +: 8] = ref_mem[a];
                end
            end
        end
        if (!wr && sel != 4'b0000) exp_dfm = rword;

        check({tag, "_busy"}, 64'(busy_cnt), 64'((sel == 4'b0000) ? 1 : n * (1 + WAITC)));
        check({tag, "_dfm"}, 64'(bus.data_from_mem), 64'(exp_dfm));
        if (wr) begin
            check({tag, "_we_cycles"}, 64'(we_log.size()), 64'(n * WAITC));
            check({tag, "_re_cycles"}, 64'(re_log.size()), 64'(0));
            for (int k = 0; k < exp_q.size() && k < we_log.size(); k++)
                check({tag, "_wr_beat"}, 64'(we_log[k]), 64'(exp_q[k]));
        end else begin
            check({tag, "_re_cycles"}, 64'(re_log.size()), 64'(n * WAITC));
            check({tag, "_we_cycles"}, 64'(we_log.size()), 64'(0));
        end
        if (sel == 4'b0000) check({tag, "_no_ce"}, 64'(ce_cnt), 64'(0));
    endtask

    initial begin
        int          guard;
        int          op;
        logic [31:0] radr;
        checks  = 0;
        passes  = 0;
        overlap = 0;
        ce_cnt  = 0;
        exp_dfm = '0;
        for (int i = 0; i < MEMSZ; i++) begin
            sram[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.write_to_mem = 1'b0;
        bus.read_to_mem  = 1'b0;
        bus.adr_to_mem   = '0;
        bus.data_to_mem  = '0;
        bus.sel_to_mem   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.mem_busy), 64'(0));
        check("rst_dfm", 64'(bus.data_from_mem), 64'(0));
        check("rst_adr", 64'(sram_adr), 64'(0));
        check("rst_dq", 64'({sram_dq_o, sram_dq_oe}), 64'(0));
        check("rst_ctl", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'(3'b111));
        rst = 1'b0;

        do_access(1'b1, 1'b0, 32'h0000_0124, 32'hDEAD_BEEF, 4'b1111, "wr_full");
        do_access(1'b0, 1'b1, 32'h0000_0124, 32'h0, 4'b1111, "rd_full");
        check("rd_full_const", 64'(bus.data_from_mem), 64'(32'hDEAD_BEEF));

        do_access(1'b1, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF, 4'b1111, "wr_fill");
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'h1122_3344, 4'b0101, "wr_part");
        do_access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b1111, "rd_part");
        check("rd_part_const", 64'(bus.data_from_mem), 64'(32'hFF22_FF44));

        do_access(1'b1, 1'b1, 32'h0000_0124, 32'h0000_0055, 4'b0001, "both");
        do_access(1'b0, 1'b1, 32'h0000_0124, 32'h0, 4'b0000, "sel0");

        // Reset during the third byte of a write
        @(negedge clk);
        bus.write_to_mem = 1'b1;
        bus.adr_to_mem   = 32'h0000_0300;
        bus.data_to_mem  = 32'hA5B6_C7D8;
        bus.sel_to_mem   = 4'b1111;
        @(posedge clk);
        #1;
        bus.write_to_mem = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(!sram_ce_n && sram_adr[1:0] == 2'd2) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("mid_rst_reached", 64'(guard < 100), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", 64'(bus.mem_busy), 64'(0));
        check("mid_rst_ctl", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'(3'b111));
        check("mid_rst_dqoe", 64'(sram_dq_oe), 64'(0));
        check("mid_rst_dfm", 64'(bus.data_from_mem), 64'(0));
        ref_mem[18'h300] = 8'hD8;
        ref_mem[18'h301] = 8'hC7;
        exp_dfm = '0;
        do_access(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'b1111, "after_rst");

        // Randomized traffic over a small aliased window
        for (int t = 0; t < 24; t++) begin
            op   = $urandom_range(0, 3);
            radr = ($urandom & 32'hFFFC_0000) | (32'h0000_0400 + ($urandom_range(0, 7) << 2));
            do_access(op == 1 || op == 2, op != 1, radr, $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        check("oe_dq_overlap", 64'(overlap), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
